// File: rtl/fir2p_frame_ctrl.sv
// rtl/fir2p_frame_ctrl.sv - pairs a serial sample stream for the two-path FIR, flushes its tail and tags its outputs
`timescale 1ns/1ps

module fir2p_frame_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 32,
    parameter int NUM_TAPS = 174,
    parameter int LAT      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              fir_en,
    output logic [DATA_W-1:0] fir_x_even,
    output logic [DATA_W-1:0] fir_x_odd,
    input  logic [ACC_W-1:0]  fir_y_even,
    input  logic [ACC_W-1:0]  fir_y_odd,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_even,
    output logic [ACC_W-1:0]  out_odd,
    output logic              out_last,
    output logic              busy,
    output logic [15:0]       stall_cnt
);

    localparam int FLUSH_PAIRS = (NUM_TAPS + 1) / 2;
    localparam int FLUSH_TOTAL = FLUSH_PAIRS + LAT;
    localparam int CNT_W       = $clog2(FLUSH_TOTAL);

    localparam logic [CNT_W-1:0] LAST_VALID = CNT_W'(FLUSH_PAIRS - 1);
    localparam logic [CNT_W-1:0] NUM_VALID  = CNT_W'(FLUSH_PAIRS);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(FLUSH_TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE,
        ODD,
        FLUSH
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] even_reg;
    logic              in_frame;
    logic [CNT_W-1:0]  flush_cnt;
    logic              cur_v;
    logic              cur_l;
    logic [LAT-1:0]    tag_v;
    logic [LAT-1:0]    tag_l;
    logic              accept;

    assign accept = in_valid & in_ready;

    // rst_n is the legacy name of an active-high asynchronous reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            even_reg   <= '0;
            in_frame   <= 1'b0;
            flush_cnt  <= '0;
            cur_v      <= 1'b0;
            cur_l      <= 1'b0;
            tag_v      <= '0;
            tag_l      <= '0;
            fir_en     <= 1'b0;
            fir_x_even <= '0;
            fir_x_odd  <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_even   <= '0;
            out_odd    <= '0;
            busy       <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            fir_en    <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;

            // The tag leaving the pipe belongs to the pair now on fir_y.
            if (fir_en) begin
                for (int i = LAT - 1; i > 0; i--) begin
                    tag_v[i] <= tag_v[i-1];
                    tag_l[i] <= tag_l[i-1];
                end
                tag_v[0] <= cur_v;
                tag_l[0] <= cur_l;
                if (tag_v[LAT-1]) begin
                    out_valid <= 1'b1;
                    out_last  <= tag_l[LAT-1];
                    out_even  <= fir_y_even;
                    out_odd   <= fir_y_odd;
                end
            end

            if ((state == ODD || (state == IDLE && in_frame)) && !in_valid
                && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end

            case (state)
                IDLE: begin
                    busy <= accept;
                    if (accept) begin
                        if (!in_frame) begin
                            stall_cnt <= '0;
                        end
                        if (in_last) begin
                            fir_en     <= 1'b1;
                            fir_x_even <= in_data;
                            fir_x_odd  <= '0;
                            cur_v      <= 1'b1;
                            cur_l      <= 1'b0;
                            in_frame   <= 1'b0;
                            flush_cnt  <= '0;
                            in_ready   <= 1'b0;
                            state      <= FLUSH;
                        end else begin
                            even_reg <= in_data;
                            in_frame <= 1'b1;
                            state    <= ODD;
                        end
                    end
                end
                ODD: begin
                    if (accept) begin
                        fir_en     <= 1'b1;
                        fir_x_even <= even_reg;
                        fir_x_odd  <= in_data;
                        cur_v      <= 1'b1;
                        cur_l      <= 1'b0;
                        if (in_last) begin
                            in_frame  <= 1'b0;
                            flush_cnt <= '0;
                            in_ready  <= 1'b0;
                            state     <= FLUSH;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    // Zero pairs: the first FLUSH_PAIRS carry filter tail, the rest only drain it.
                    busy       <= 1'b1;
                    fir_en     <= 1'b1;
                    fir_x_even <= '0;
                    fir_x_odd  <= '0;
                    cur_v      <= (flush_cnt < NUM_VALID);
                    cur_l      <= (flush_cnt == LAST_VALID);
                    if (flush_cnt == LAST_DRAIN) begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fir2p_frame_ctrl.md
# fir2p_frame_ctrl

Frame sequencer for the clock-enabled two-path FIR filter. It accepts a serial sample stream with a valid/ready handshake and packs consecutive samples into even/odd pairs. It advances the filter with one enable per pair, then appends zero pairs so the filter tail is flushed. A tag pipeline marks which filter output pairs are valid and which one ends the frame. It sits between the sample source (chirp/test generator or ADC front end) and the downstream output sink.

## Interface
- DATA_W, 16, input sample width (signed)
- ACC_W, 32, filter output width (signed)
- NUM_TAPS, 174, filter length; derived FLUSH_PAIRS = (NUM_TAPS+1)/2 (87 at default)
- LAT, 2, filter latency in enabled cycles (pair issued on enable k appears on fir_y_* after enable k+LAT)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- in_valid  in  1  sample valid
- in_ready  out  1  sample accepted when in_valid & in_ready
- in_data  in  DATA_W  signed sample
- in_last  in  1  marks final sample of frame
- fir_en  out  1  filter advance enable, registered
- fir_x_even  out  DATA_W  even sample to filter, registered
- fir_x_odd  out  DATA_W  odd sample to filter, registered
- fir_y_even  in  ACC_W  filter even output
- fir_y_odd  in  ACC_W  filter odd output
- out_valid  out  1  output pair valid (one-cycle pulse)
- out_even  out  ACC_W  captured fir_y_even
- out_odd  out  ACC_W  captured fir_y_odd
- out_last  out  1  with out_valid, final pair of frame
- busy  out  1  state != IDLE
- stall_cnt  out  16  saturating count of mid-frame starved cycles, cleared at frame start

## Operation
- FSM states: IDLE, ODD, FLUSH.
- IDLE: in_ready=1.
  - Accept → latch even_reg; clear stall_cnt.
  - With in_last=0 → ODD.
  - With in_last=1 → issue pair (sample, 0) → FLUSH.
- ODD: in_ready=1.
  - Accept → issue pair (even_reg, sample).
  - in_last=0 → IDLE, marked mid-frame.
  - in_last=1 → FLUSH.
- Mid-frame starvation: any cycle in ODD, or in IDLE after a frame has started, with in_valid=0 increments stall_cnt (saturates at 0xFFFF). fir_en stays 0, so the filter holds.
- Issue pair: the next cycle has fir_en=1 and fir_x_even/odd = pair. Otherwise fir_en=0 and fir_x_* hold their last value.
- FLUSH: in_ready=0. Issues zero pairs on consecutive cycles, FLUSH_PAIRS+LAT in total, then returns to IDLE (frame ended).
  - The first FLUSH_PAIRS zero pairs are tagged valid.
  - The last LAT zero pairs are tagged invalid and only drain the pipeline.
- Tag pipe: LAT entries of {valid, last}, shifting only on fir_en.
  - Data pairs are tagged {1,0}.
  - Flush pairs are tagged {1,0}; the last valid flush pair is tagged {1,1}.
  - Drain pairs are tagged {0,0}.
- Output: in the cycle after fir_en, if the tag shifting out is valid:
  - out_valid=1 and out_last=tag.last;
  - out_even/out_odd = fir_y_even/odd sampled on that fir_en edge.
- Arithmetic: none on data. Zero padding is signed 0. Pair count per frame is ceil(N/2) for N input samples.

## Timing
- Reset (async): state IDLE, in_ready=1, fir_en=0, fir_x_*=0, out_valid=0, out_last=0, out_*=0, busy=0, stall_cnt=0, tag pipe cleared.
- Reset mid-FLUSH or mid-frame: all of the above immediately. A partial pair in even_reg is discarded.
- Accept-to-fir_en latency: 1 cycle after the odd (or last) sample.
- fir_en-to-out_valid: the output for a pair appears the cycle after the LAT-th subsequent fir_en.
- FLUSH duration: exactly FLUSH_PAIRS+LAT cycles with fir_en=1 continuously.
- out_last asserts exactly once per frame. busy deasserts the cycle after the final drain fir_en.
- in_valid during FLUSH: ignored, nothing accepted. The first new accept is possible on the first IDLE cycle.
- in_valid=1 with in_last=1 on the first sample: treated as a one-sample frame, issued as (s, 0).

## Test plan
- Reset: rst_n asserted → next cycle in_ready=1, fir_en=0, out_valid=0, stall_cnt=0. With LAT=2 and a pass-through filter model:
  - Frame 1, 2, 3, 4 (last on 4) → fir_en pairs (1, 2), (3, 4), then 89 zero pairs.
  - 89 out_valid pulses; out_last on the 89th only.
- Odd frame 5, 6, 7 → pairs (5, 6), (7, 0), then 89 zero pairs; 89 out_valid; out_last once.
- Stall: in_valid low for 5 cycles between samples 2 and 3 of a 4-sample frame → no fir_en during the gap, stall_cnt=5, output values unchanged versus the unstalled run.
- in_valid held high during FLUSH → in_ready=0 for 89 cycles, no accept. Next frame's first sample is accepted on the first IDLE cycle.
- Assert rst_n 10 cycles into FLUSH → outputs at reset values next cycle, no out_last. A new frame afterwards runs exactly as the 1, 2, 3, 4 case.
